// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute
// and driving the ALU datapath selects, ALUControl and write enables.
module mips_multicycle_ctrl #(
  parameter int OP_WIDTH         = 6,
  parameter int FUNCT_WIDTH      = 6,
  parameter int ALUControl_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [OP_WIDTH-1:0]         Op,
  input  logic [FUNCT_WIDTH-1:0]      Funct,
  input  logic                        Zero_flag,
  output logic                        IorD,
  output logic                        MemWrite,
  output logic                        IRWrite,
  output logic                        RegDst,
  output logic                        MemtoReg,
  output logic                        RegWrite,
  output logic                        ALUSrcA,
  output logic [1:0]                  ALUSrcB,
  output logic [ALUControl_WIDTH-1:0] ALUControl,
  output logic [1:0]                  PCSrc,
  output logic                        PCEn,
  output logic [3:0]                  state,
  output logic                        illegal_instr,
  output logic                        instr_done
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);

  localparam logic [ALUControl_WIDTH-1:0] ALU_AND = ALUControl_WIDTH'(3'b000);
  localparam logic [ALUControl_WIDTH-1:0] ALU_OR  = ALUControl_WIDTH'(3'b001);
  localparam logic [ALUControl_WIDTH-1:0] ALU_ADD = ALUControl_WIDTH'(3'b010);
  localparam logic [ALUControl_WIDTH-1:0] ALU_SUB = ALUControl_WIDTH'(3'b100);
  localparam logic [ALUControl_WIDTH-1:0] ALU_MUL = ALUControl_WIDTH'(3'b101);
  localparam logic [ALUControl_WIDTH-1:0] ALU_SLT = ALUControl_WIDTH'(3'b110);

  state_t                        state_q, state_d;
  logic                          funct_ok;
  logic [ALUControl_WIDTH-1:0]   funct_alu;
  logic                          pc_write, branch;

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (Funct)
      FUNCT_WIDTH'(6'b100100): funct_alu = ALU_AND;
      FUNCT_WIDTH'(6'b100101): funct_alu = ALU_OR;
      FUNCT_WIDTH'(6'b100000): funct_alu = ALU_ADD;
      FUNCT_WIDTH'(6'b100010): funct_alu = ALU_SUB;
      FUNCT_WIDTH'(6'b011000): funct_alu = ALU_MUL;
      FUNCT_WIDTH'(6'b101010): funct_alu = ALU_SLT;
      default:                 funct_ok  = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    IorD          = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUControl    = ALU_AND;
    PCSrc         = 2'b00;
    pc_write      = 1'b0;
    branch        = 1'b0;
    illegal_instr = 1'b0;
    instr_done    = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        IRWrite    = 1'b1;
        pc_write   = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode decodes.
        ALUSrcB    = 2'b11;
        ALUControl = ALU_ADD;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_EXEC : S_FETCH;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
        if (state_d == S_FETCH) begin
          illegal_instr = 1'b1;
          instr_done    = 1'b1;
        end
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        if (state_q == S_ADDIEX) state_d = S_ADDIWB;
        else                     state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    PCEn  = pc_write | (branch & Zero_flag);
    state = state_q;

    // Reset kills every enable in the same cycle so an abandoned instruction
    // never completes a partial write.
    if (!rst_n) begin
      IorD          = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ALUControl    = ALU_AND;
      PCSrc         = 2'b00;
      PCEn          = 1'b0;
      state         = 4'd0;
      illegal_instr = 1'b0;
      instr_done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: instruction-level model of state
// sequences and per-state control words, checked every cycle, plus pinned literals.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op, Funct;
  logic       Zero_flag;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn, illegal_instr, instr_done;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero_flag(Zero_flag),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn),
    .state(state), .illegal_instr(illegal_instr), .instr_done(instr_done)
  );

  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctl;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [3:0] st;
    logic       ill, done;
  } outs_t;

  int    n_total = 0;
  int    n_bad   = 0;
  bit    chk_en  = 1'b0;
  outs_t exp_o, act_o;
  outs_t tr [6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic outs_t dut_outs();
    outs_t o;
    o.iord = IorD;       o.memwrite = MemWrite; o.irwrite = IRWrite;
    o.regdst = RegDst;   o.memtoreg = MemtoReg; o.regwrite = RegWrite;
    o.alusrca = ALUSrcA; o.alusrcb = ALUSrcB;   o.aluctl = ALUControl;
    o.pcsrc = PCSrc;     o.pcen = PCEn;         o.st = state;
    o.ill = illegal_instr; o.done = instr_done;
    return o;
  endfunction

  // ---------------- behavioural model ----------------
  function automatic logic [2:0] alu_of(input logic [5:0] f, output bit ok);
    ok = 1'b1;
    case (f)
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100000: return 3'b010;
      6'b100010: return 3'b100;
      6'b011000: return 3'b101;
      6'b101010: return 3'b110;
      default: begin ok = 1'b0; return 3'b000; end
    endcase
  endfunction

  // Expected state walk for one instruction, FETCH first; returns its length.
  function automatic int plan(input logic [5:0] op, input logic [5:0] f,
                              output int seq [6], output bit ill);
    bit ok;
    logic [2:0] unused_alu;
    seq = '{0, 1, 0, 0, 0, 0};
    ill = 1'b0;
    case (op)
      6'b100011: begin seq[2] = 2; seq[3] = 3; seq[4] = 4; return 5; end
      6'b101011: begin seq[2] = 2; seq[3] = 5; return 4; end
      6'b000000: begin
        unused_alu = alu_of(f, ok);
        if (ok) begin seq[2] = 6; seq[3] = 7; return 4; end
        ill = 1'b1; return 2;
      end
      6'b000100: begin seq[2] = 8; return 3; end
      6'b001000: begin seq[2] = 9; seq[3] = 10; return 4; end
      6'b000010: begin seq[2] = 11; return 3; end
      default:   begin ill = 1'b1; return 2; end
    endcase
  endfunction

  function automatic outs_t exp_out(input int s, input logic [5:0] f,
                                    input logic z, input bit ill);
    outs_t o = '0;
    bit ok;
    o.st = 4'(s);
    case (s)
      0:    begin o.alusrcb = 2'b01; o.aluctl = 3'b010; o.irwrite = 1; o.pcen = 1; end
      1:    begin o.alusrcb = 2'b11; o.aluctl = 3'b010; o.ill = ill; o.done = ill; end
      2, 9: begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluctl = 3'b010; end
      3:    o.iord = 1;
      4:    begin o.memtoreg = 1; o.regwrite = 1; o.done = 1; end
      5:    begin o.iord = 1; o.memwrite = 1; o.done = 1; end
      6:    begin o.alusrca = 1; o.aluctl = alu_of(f, ok); end
      7:    begin o.regdst = 1; o.regwrite = 1; o.done = 1; end
      8:    begin o.alusrca = 1; o.aluctl = 3'b100; o.pcsrc = 2'b01; o.pcen = z; o.done = 1; end
      10:   begin o.regwrite = 1; o.done = 1; end
      11:   begin o.pcsrc = 2'b10; o.pcen = 1; o.done = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      act_o = dut_outs();
      check("IorD",          8'(act_o.iord),     8'(exp_o.iord));
      check("MemWrite",      8'(act_o.memwrite), 8'(exp_o.memwrite));
      check("IRWrite",       8'(act_o.irwrite),  8'(exp_o.irwrite));
      check("RegDst",        8'(act_o.regdst),   8'(exp_o.regdst));
      check("MemtoReg",      8'(act_o.memtoreg), 8'(exp_o.memtoreg));
      check("RegWrite",      8'(act_o.regwrite), 8'(exp_o.regwrite));
      check("ALUSrcA",       8'(act_o.alusrca),  8'(exp_o.alusrca));
      check("ALUSrcB",       8'(act_o.alusrcb),  8'(exp_o.alusrcb));
      check("ALUControl",    8'(act_o.aluctl),   8'(exp_o.aluctl));
      check("PCSrc",         8'(act_o.pcsrc),    8'(exp_o.pcsrc));
      check("PCEn",          8'(act_o.pcen),     8'(exp_o.pcen));
      check("state",         8'(act_o.st),       8'(exp_o.st));
      check("illegal_instr", 8'(act_o.ill),      8'(exp_o.ill));
      check("instr_done",    8'(act_o.done),     8'(exp_o.done));
    end
  end

  // Runs one instruction starting 1 time unit into its FETCH cycle; records the
  // DUT outputs of each cycle into tr[]. abort_at drops rst_n in that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                           input logic z, input int abort_at);
    int seq [6];
    bit ill;
    int n;
    n = plan(op, f, seq, ill);
    tr = '{default: '0};
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      Op = op; Funct = f; Zero_flag = z;
      if (i == abort_at) begin
        rst_n = 1'b0;
        exp_o = '0;
      end else begin
        exp_o = exp_out(seq[i], f, z, ill);
      end
      #5 tr[i] = dut_outs();
      if (i == abort_at) break;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; Op = 6'b100011; Funct = 6'b000000; Zero_flag = 1'b0;
    exp_o = '0;
    chk_en = 1'b1;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #6;
      check("rst_state", 8'(state), 8'd0);
      check("rst_pcen",  8'(PCEn),  8'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // lw
    run_instr(6'b100011, 6'b000000, 1'b0, -1);
    check("rel_irwrite", 8'(tr[0].irwrite), 8'd1);
    check("rel_pcen",    8'(tr[0].pcen),    8'd1);
    check("rel_alusrcb", 8'(tr[0].alusrcb), 8'd1);
    check("rel_aluctl",  8'(tr[0].aluctl),  8'd2);
    for (int i = 0; i < 5; i++) check($sformatf("lw_st%0d", i), 8'(tr[i].st), 8'(i));
    check("lw_iord3",     8'(tr[3].iord),     8'd1);
    check("lw_rw3",       8'(tr[3].regwrite), 8'd0);
    check("lw_rw4",       8'(tr[4].regwrite), 8'd1);
    check("lw_m2r4",      8'(tr[4].memtoreg), 8'd1);
    check("lw_done3",     8'(tr[3].done),     8'd0);
    check("lw_done4",     8'(tr[4].done),     8'd1);

    // R-type: sub, slt, mul with literal ALUControl pins
    run_instr(6'b000000, 6'b100010, 1'b1, -1);
    check("lw_next_st", 8'(tr[0].st), 8'd0);
    check("sub_alu",    8'(tr[2].aluctl),   8'b100);
    check("sub_regdst", 8'(tr[3].regdst),   8'd1);
    check("sub_rw",     8'(tr[3].regwrite), 8'd1);
    run_instr(6'b000000, 6'b101010, 1'b0, -1);
    check("slt_alu", 8'(tr[2].aluctl), 8'b110);
    run_instr(6'b000000, 6'b011000, 1'b1, -1);
    check("mul_alu", 8'(tr[2].aluctl), 8'b101);
    run_instr(6'b000000, 6'b100100, 1'b0, -1);
    run_instr(6'b000000, 6'b100101, 1'b0, -1);
    run_instr(6'b000000, 6'b100000, 1'b1, -1);

    // addi and a full sw
    run_instr(6'b001000, 6'b010101, 1'b1, -1);
    run_instr(6'b101011, 6'b000000, 1'b0, -1);
    check("sw_mw3", 8'(tr[3].memwrite), 8'd1);

    // beq taken / not taken
    run_instr(6'b000100, 6'b000000, 1'b1, -1);
    check("beq1_st",    8'(tr[2].st),    8'd8);
    check("beq1_pcen",  8'(tr[2].pcen),  8'd1);
    check("beq1_pcsrc", 8'(tr[2].pcsrc), 8'd1);
    run_instr(6'b000100, 6'b000000, 1'b0, -1);
    check("beq1_next", 8'(tr[0].st),   8'd0);
    check("beq0_pcen", 8'(tr[2].pcen), 8'd0);

    // illegal opcode, then R-type with unsupported funct
    run_instr(6'b111111, 6'b000000, 1'b1, -1);
    check("beq0_next", 8'(tr[0].st),       8'd0);
    check("ill1_p0",   8'(tr[0].ill),      8'd0);
    check("ill1_p1",   8'(tr[1].ill),      8'd1);
    check("ill1_rw",   8'(tr[1].regwrite), 8'd0);
    check("ill1_mw",   8'(tr[1].memwrite), 8'd0);
    check("ill1_pcen", 8'(tr[1].pcen),     8'd0);
    run_instr(6'b000000, 6'b000111, 1'b1, -1);
    check("ill1_next", 8'(tr[0].st),  8'd0);
    check("ill1_p2",   8'(tr[0].ill), 8'd0);
    check("ill2_st1",  8'(tr[1].st),  8'd1);
    check("ill2_p1",   8'(tr[1].ill), 8'd1);

    // sw abandoned by reset during MEMWR, then instructions resume
    run_instr(6'b101011, 6'b000000, 1'b0, 3);
    check("ill2_next", 8'(tr[0].st),       8'd0);
    check("abort_mw",  8'(tr[3].memwrite), 8'd0);
    check("abort_st",  8'(tr[3].st),       8'd0);
    run_instr(6'b001000, 6'b000000, 1'b0, -1);
    check("abort_next_st", 8'(tr[0].st),       8'd0);
    check("addi_rw",       8'(tr[3].regwrite), 8'd1);
    check("addi_st3",      8'(tr[3].st),       8'd10);

    // jump
    run_instr(6'b000010, 6'b000000, 1'b0, -1);
    check("j_st",    8'(tr[2].st),    8'd11);
    check("j_pcsrc", 8'(tr[2].pcsrc), 8'd2);
    check("j_pcen",  8'(tr[2].pcen),  8'd1);

    exp_o = exp_out(0, 6'b000000, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS main controller. It sequences each instruction through a Moore FSM and drives the datapath that feeds the ALU: operand selects, ALUControl, and the register, memory and PC write enables. It consumes the ALU's Zero_flag to resolve branches. It replaces the single-cycle control decode when the core moves to the shared-memory multicycle datapath.

Parameters:
OP_WIDTH, 6, opcode field width
FUNCT_WIDTH, 6, funct field width
ALUControl_WIDTH, 3, ALU operation code width; encoding fixed: 000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
Op  in  6  instruction[31:26] from instruction register
Funct  in  6  instruction[5:0] from instruction register
Zero_flag  in  1  ALU zero flag, combinational from current ALU operation
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register load
RegDst  out  1  write-register select: 0 = rt, 1 = rd
MemtoReg  out  1  write-data select: 0 = ALUOut, 1 = memory data
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
ALUControl  out  3  ALU operation, encoding as above
PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
PCEn  out  1  PC load = PCWrite | (Branch & Zero_flag)
state  out  4  current FSM state, for debug
illegal_instr  out  1  one-cycle pulse on an unsupported opcode or funct
instr_done  out  1  high in the last cycle of each instruction

Behaviour:
- Reset: while rst_n = 0, every output is forced to 0 combinationally. The state register loads FETCH on the next edge. The first cycle after release is FETCH.
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, ALUWB = 7, BEQ = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
  - Codes 12–15 go to FETCH on the next edge, with all outputs 0.
- Outputs depend on the current state only. The one exception is PCEn, which also uses Zero_flag. Any signal not listed for a state is 0.
  - FETCH: ALUSrcB = 01, ALUControl = 010, IRWrite = 1, PCWrite = 1 (PCSrc = 00).
  - DECODE: ALUSrcB = 11, ALUControl = 010 (branch target into ALUOut).
  - MEMADR and ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUControl = 010.
  - MEMRD: IorD = 1.
  - MEMWR: IorD = 1, MemWrite = 1.
  - MEMWB: MemtoReg = 1, RegWrite = 1.
  - EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUControl from Funct:
    - 100100 → 000, 100101 → 001, 100000 → 010
    - 100010 → 100, 011000 → 101, 101010 → 110
  - ALUWB: RegDst = 1, RegWrite = 1.
  - ADDIWB: RegWrite = 1.
  - BEQ: ALUSrcA = 1, ALUSrcB = 00, ALUControl = 100, PCSrc = 01, Branch = 1.
  - JUMP: PCSrc = 10, PCWrite = 1.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by Op:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) with a supported Funct → EXEC
    - 000100 (beq) → BEQ
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JUMP
    - anything else, including R-type with an unsupported Funct → FETCH, with illegal_instr = 1 during that DECODE cycle
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB.
  - EXEC → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BEQ and JUMP → FETCH.
- Latency in cycles, FETCH included: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- instr_done is high in MEMWB, MEMWR, ALUWB, ADDIWB, BEQ, JUMP, and in DECODE when the instruction is illegal.
- Op and Funct are only meaningful from DECODE onward. The IR holds them stable until the next FETCH. Only Funct is used in EXEC.
- Reset asserted mid-instruction: write enables drop to 0 in that same cycle, and the instruction is abandoned with no partial write. Execution restarts at FETCH.
- BEQ: PCEn follows Zero_flag combinationally within the cycle. There is no registered branch decision.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with Op = 100011 → all outputs 0 and state = 0 throughout. After release: state = 0, IRWrite = 1, PCEn = 1, ALUSrcB = 01, ALUControl = 010.
- lw (Op = 100011) → state sequence 0, 1, 2, 3, 4, 0. IorD = 1 in state 3. RegWrite = 1 and MemtoReg = 1 only in state 4. instr_done = 1 only in state 4.
- R-type: Op = 000000 with Funct = 100010 → ALUControl = 100 in EXEC. Repeat with Funct = 101010 → 110, and with Funct = 011000 → 101. ALUWB asserts RegDst = 1 and RegWrite = 1.
- beq (Op = 000100): Zero_flag = 1 → PCEn = 1 and PCSrc = 01 in state 8. Zero_flag = 0 → PCEn = 0. Both cases return to state 0 next cycle.
- Illegal instructions: Op = 111111, then Op = 000000 with Funct = 000111 → state sequence 0, 1, 0. illegal_instr pulses for exactly one cycle. RegWrite, MemWrite and PCEn are 0 in DECODE.
- Reset mid-instruction: sw, with rst_n dropped during MEMWR → MemWrite = 0 in that cycle. state = 0 after the edge, and the next instruction completes normally. Also run j (Op = 000010) → PCSrc = 10 and PCEn = 1 in state 11.
